// File: rtl/uart_cat_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cat_ctrl_pkg
// Function : Shared FSM state encoding and reply/command byte codes.
// Revision : 1.0
// ============================================================================
package cat_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    DECODE  = 3'd2,
    SEND_HI = 3'd3,
    SEND_LO = 3'd4
  } state_t;

  localparam logic [7:0] c_ack            = 8'h06;
  localparam logic [7:0] c_nak            = 8'h15;
  localparam logic [7:0] c_def_upper_base = 8'h41;
  localparam logic [7:0] c_def_lower_base = 8'h61;
  localparam logic [7:0] c_def_clear_all  = 8'h60;
  localparam logic [7:0] c_def_query      = 8'h3F;

endpackage
`default_nettype wire

// File: rtl/uart_cat_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_cat_controller_if
// Function : RX/TX FIFO handshake bundle between UART core and controller.
// Revision : 1.0
// ============================================================================
interface uart_cat_controller_if;

  logic       rx_empty;
  logic [7:0] rx_data;
  logic       rx_rd;
  logic       tx_full;
  logic [7:0] tx_data;
  logic       tx_wr;

  modport master (
    input  rx_empty, rx_data, tx_full,
    output rx_rd, tx_data, tx_wr
  );

  modport slave (
    output rx_empty, rx_data, tx_full,
    input  rx_rd, tx_data, tx_wr
  );

endinterface
`default_nettype wire

// File: rtl/uart_cat_controller_nibble_to_hex.sv
`default_nettype none
// ============================================================================
// Module   : nibble_to_hex
// Function : 4-bit value to uppercase ASCII hex digit.
// Revision : 1.0
// ============================================================================
module nibble_to_hex (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_hex
);

  // 'A' (8'h41) minus 10 is 8'h37
  assign o_hex = (i_nibble < 4'd10) ? (8'h30 + {4'h0, i_nibble})
                                    : (8'h37 + {4'h0, i_nibble});

endmodule
`default_nettype wire

// File: rtl/uart_cat_controller.sv
`default_nettype none
// ============================================================================
// Module   : uart_cat_controller
// Function : Pops RX command bytes, updates the cat mask, replies via TX FIFO.
// Revision : 1.0
// ============================================================================
module uart_cat_controller
  import cat_ctrl_pkg::*;
#(
  parameter int         NUM_CATS   = 8,
  parameter logic [7:0] UPPER_BASE = c_def_upper_base,
  parameter logic [7:0] LOWER_BASE = c_def_lower_base,
  parameter logic [7:0] CLEAR_ALL  = c_def_clear_all,
  parameter logic [7:0] QUERY      = c_def_query,
  parameter bit         ACK_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  uart_cat_controller_if.master fifo,
  output logic [NUM_CATS-1:0]   cat_status,
  output logic [7:0]            err_count,
  output logic                  busy
);

  state_t              r_state, w_state_next;
  logic [NUM_CATS-1:0] r_cat_status, w_cat_status_next;
  logic [7:0]          r_err_count, w_err_count_next;
  logic [3:0]          r_snap_hi, w_snap_hi_next;
  logic [7:0]          r_reply, w_reply_next;

  logic [7:0] w_status_ext;
  logic [7:0] w_hex_hi;
  logic [7:0] w_hex_lo;
  logic [8:0] w_upper_off;
  logic [8:0] w_lower_off;
  logic       w_is_clear_all;
  logic       w_is_query;
  logic       w_in_upper;
  logic       w_in_lower;

  always_comb begin
    w_status_ext                 = '0;
    w_status_ext[NUM_CATS-1:0]   = r_cat_status;
  end

  // 9-bit offsets so a byte below the base cannot wrap into range
  assign w_upper_off    = {1'b0, fifo.rx_data} - {1'b0, UPPER_BASE};
  assign w_lower_off    = {1'b0, fifo.rx_data} - {1'b0, LOWER_BASE};
  assign w_is_clear_all = (fifo.rx_data == CLEAR_ALL);
  assign w_is_query     = (fifo.rx_data == QUERY);
  assign w_in_upper     = (fifo.rx_data >= UPPER_BASE) && (w_upper_off < 9'(NUM_CATS));
  assign w_in_lower     = (fifo.rx_data >= LOWER_BASE) && (w_lower_off < 9'(NUM_CATS));

  nibble_to_hex u_hex_hi (
    .i_nibble (r_snap_hi),
    .o_hex    (w_hex_hi)
  );

  nibble_to_hex u_hex_lo (
    .i_nibble (w_status_ext[3:0]),
    .o_hex    (w_hex_lo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cat_status <= '1;
      r_err_count  <= 8'h00;
      r_snap_hi    <= 4'h0;
      r_reply      <= 8'h00;
    end else begin
      r_state      <= w_state_next;
      r_cat_status <= w_cat_status_next;
      r_err_count  <= w_err_count_next;
      r_snap_hi    <= w_snap_hi_next;
      r_reply      <= w_reply_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cat_status_next = r_cat_status;
    w_err_count_next  = r_err_count;
    w_snap_hi_next    = r_snap_hi;
    w_reply_next      = r_reply;
    fifo.rx_rd        = 1'b0;
    fifo.tx_wr        = 1'b0;
    fifo.tx_data      = 8'h00;
    busy              = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (!fifo.rx_empty) begin
          fifo.rx_rd   = 1'b1;
          w_state_next = POP;
        end
      end

      POP: w_state_next = DECODE;

      DECODE: begin
        // Priority: CLEAR_ALL > QUERY > upper range > lower range
        if (w_is_clear_all) begin
          w_cat_status_next = '1;
          w_reply_next      = c_ack;
          w_state_next      = ACK_EN ? SEND_LO : IDLE;
        end else if (w_is_query) begin
          w_snap_hi_next = w_status_ext[7:4];
          w_reply_next   = w_hex_lo;
          w_state_next   = SEND_HI;
        end else if (w_in_upper) begin
          for (int i = 0; i < NUM_CATS; i++) begin
            if (w_upper_off == 9'(i)) w_cat_status_next[i] = 1'b0;
          end
          w_reply_next = c_ack;
          w_state_next = ACK_EN ? SEND_LO : IDLE;
        end else if (w_in_lower) begin
          for (int i = 0; i < NUM_CATS; i++) begin
            if (w_lower_off == 9'(i)) w_cat_status_next[i] = 1'b1;
          end
          w_reply_next = c_ack;
          w_state_next = ACK_EN ? SEND_LO : IDLE;
        end else begin
          if (r_err_count != 8'hFF) w_err_count_next = r_err_count + 8'h01;
          w_reply_next = c_nak;
          w_state_next = SEND_LO;
        end
      end

      SEND_HI: begin
        fifo.tx_data = w_hex_hi;
        if (!fifo.tx_full) begin
          fifo.tx_wr   = 1'b1;
          w_state_next = SEND_LO;
        end
      end

      SEND_LO: begin
        fifo.tx_data = r_reply;
        if (!fifo.tx_full) begin
          fifo.tx_wr   = 1'b1;
          w_state_next = IDLE;
        end
      end

      default: w_state_next = IDLE;
    endcase
  end

  assign cat_status = r_cat_status;
  assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_cat_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cat_controller
// Function : Directed self-checking bench for uart_cat_controller.
// Revision : 1.0
// ============================================================================
module tb_uart_cat_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] cat_status, cat_status0;
  logic [7:0] err_count, err_count0;
  logic       busy, busy0;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_mem [0:511];
  int         rx_wp = 0;
  int         rx_rp = 0;
  logic [7:0] tx_log [0:1023];
  int         tx_cnt = 0;
  int         rx_pulses = 0;
  int         rd_empty_viol = 0;
  logic [7:0] tx0_last = 8'h00;
  int         tx0_cnt = 0;

  uart_cat_controller_if bus ();
  uart_cat_controller_if bus0 ();

  assign bus.rx_empty = (rx_wp == rx_rp);

  uart_cat_controller u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo       (bus),
    .cat_status (cat_status),
    .err_count  (err_count),
    .busy       (busy)
  );

  uart_cat_controller #(.ACK_EN(1'b0)) u_dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo       (bus0),
    .cat_status (cat_status0),
    .err_count  (err_count0),
    .busy       (busy0)
  );

  always #5 clk = ~clk;

  // FIFO models: capture pushes mid-cycle; RX head byte appears after the pop edge
  always begin
    @(negedge clk);
    if (bus.tx_wr === 1'b1) begin
      tx_log[tx_cnt] = bus.tx_data;
      tx_cnt++;
    end
    if (bus0.tx_wr === 1'b1) begin
      tx0_last = bus0.tx_data;
      tx0_cnt++;
    end
    if (bus.rx_rd === 1'b1 && bus.rx_empty) rd_empty_viol++;
    if (bus.rx_rd === 1'b1) begin
      rx_pulses++;
      @(posedge clk);
      #1;
      bus.rx_data = rx_mem[rx_rp[8:0]];
      rx_rp++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_mem[rx_wp[8:0]] = b;
    rx_wp++;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    tick(1);
    while (!(bus.rx_empty && !busy) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $error("FAIL wait_idle_timeout observed=%0d expected<%0d", n, budget);
    end
  endtask

  task automatic send0(input logic [7:0] b);
    bus0.rx_data  = b;
    bus0.rx_empty = 1'b0;
    tick(1);
    bus0.rx_empty = 1'b1;
    tick(5);
  endtask

  initial begin
    int hold_bad;
    reset_n       = 1'b0;
    bus.tx_full   = 1'b0;
    bus.rx_data   = 8'h00;
    bus0.rx_empty = 1'b1;
    bus0.rx_data  = 8'h00;
    bus0.tx_full  = 1'b0;
    tick(2);

    check("rst_cat_status", 32'(cat_status), 32'hFF);
    check("rst_err_count",  32'(err_count),  32'h00);
    check("rst_rx_rd",      32'(bus.rx_rd),  32'h0);
    check("rst_tx_wr",      32'(bus.tx_wr),  32'h0);
    check("rst_tx_data",    32'(bus.tx_data), 32'h00);
    check("rst_busy",       32'(busy),       32'h0);
    reset_n = 1'b1;
    tick(1);

    push(8'h43);
    wait_idle(50);
    check("C_cat_status", 32'(cat_status), 32'hFB);
    check("C_err_count",  32'(err_count),  32'h00);
    check("C_tx_cnt",     32'(tx_cnt),     32'd1);
    check("C_tx_byte",    32'(tx_log[0]),  32'h06);
    check("C_rx_pulses",  32'(rx_pulses),  32'd1);

    push(8'h60); wait_idle(50);
    check("clr_all_status", 32'(cat_status), 32'hFF);
    push(8'h41); wait_idle(50);
    check("A_status", 32'(cat_status), 32'hFE);
    push(8'h42); wait_idle(50);
    check("B_status", 32'(cat_status), 32'hFC);
    push(8'h63); wait_idle(50);
    check("c_status", 32'(cat_status), 32'hFC);
    push(8'h3F); wait_idle(50);
    check("seq_tx_cnt", 32'(tx_cnt), 32'd7);
    check("seq_tx1", 32'(tx_log[1]), 32'h06);
    check("seq_tx2", 32'(tx_log[2]), 32'h06);
    check("seq_tx3", 32'(tx_log[3]), 32'h06);
    check("seq_tx4", 32'(tx_log[4]), 32'h06);
    check("query_hi", 32'(tx_log[5]), 32'h46);
    check("query_lo", 32'(tx_log[6]), 32'h43);

    push(8'h60); wait_idle(50);
    push(8'h7A); push(8'h49); wait_idle(100);
    check("bad_tx_cnt",  32'(tx_cnt),     32'd10);
    check("bad_tx_z",    32'(tx_log[8]),  32'h15);
    check("bad_tx_I",    32'(tx_log[9]),  32'h15);
    check("bad_err",     32'(err_count),  32'd2);
    check("bad_status",  32'(cat_status), 32'hFF);

    // Backpressure during a query reply, with another byte queued
    bus.tx_full = 1'b1;
    push(8'h3F); push(8'h41);
    tick(6);
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_wr !== 1'b0 || busy !== 1'b1 || bus.rx_rd !== 1'b0) hold_bad++;
      tick(1);
    end
    check("hold_bad_cycles", 32'(hold_bad), 32'd0);
    check("hold_tx_cnt",     32'(tx_cnt),    32'd10);
    check("hold_rx_pulses",  32'(rx_pulses), 32'd10);
    check("hold_rx_pending", 32'(bus.rx_empty), 32'h0);
    bus.tx_full = 1'b0;
    wait_idle(100);
    check("rel_tx_cnt", 32'(tx_cnt),     32'd13);
    check("rel_tx_hi",  32'(tx_log[10]), 32'h46);
    check("rel_tx_lo",  32'(tx_log[11]), 32'h46);
    check("rel_tx_ack", 32'(tx_log[12]), 32'h06);
    check("rel_status", 32'(cat_status), 32'hFE);

    // Reset while stalled in SEND_HI
    bus.tx_full = 1'b1;
    push(8'h3F);
    tick(6);
    check("pre_rst_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_status", 32'(cat_status), 32'hFF);
    check("mid_rst_tx_wr",  32'(bus.tx_wr),  32'h0);
    check("mid_rst_busy",   32'(busy),       32'h0);
    check("mid_rst_err",    32'(err_count),  32'h00);
    tick(2);
    reset_n = 1'b1;
    bus.tx_full = 1'b0;
    tick(5);
    check("post_rst_no_tx", 32'(tx_cnt), 32'd13);
    push(8'h44); wait_idle(50);
    check("post_rst_status", 32'(cat_status), 32'hF7);
    check("post_rst_tx_cnt", 32'(tx_cnt),     32'd14);
    check("post_rst_ack",    32'(tx_log[13]), 32'h06);

    // err_count saturation
    for (int i = 0; i < 255; i++) push(8'h7A);
    wait_idle(3000);
    check("sat_err_255", 32'(err_count), 32'hFF);
    check("sat_tx_cnt",  32'(tx_cnt),    32'd269);
    push(8'h7A); wait_idle(50);
    check("sat_err_hold", 32'(err_count),  32'hFF);
    check("sat_tx_cnt2",  32'(tx_cnt),     32'd270);
    check("sat_nak",      32'(tx_log[269]), 32'h15);
    check("rd_when_empty", 32'(rd_empty_viol), 32'd0);

    // Variant with acknowledge replies disabled
    send0(8'h41);
    check("noack_A_status", 32'(cat_status0), 32'hFE);
    check("noack_A_tx",     32'(tx0_cnt),     32'd0);
    send0(8'h61);
    check("noack_a_status", 32'(cat_status0), 32'hFF);
    check("noack_a_tx",     32'(tx0_cnt),     32'd0);
    send0(8'h7A);
    check("noack_nak_cnt",  32'(tx0_cnt),     32'd1);
    check("noack_nak_byte", 32'(tx0_last),    32'h15);
    check("noack_err",      32'(err_count0),  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
